hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipeline; companion to the forwarding logic.
- Detects load-use hazards, resolves taken branches and jumps, and absorbs data-memory wait states.
- Sequences the multi-cycle mul/div unit (MDU): start pulse, busy counter, completion hand-off.
- Drives the enable/clear inputs of the F/D, D/E, E/M and M/W pipeline registers.

---
 rtl/hazard_ctrl_pkg.sv | 6 +
 rtl/hazard_ctrl_if.sv | 18 +
 rtl/hazard_ctrl_mdu_sequencer.sv | 40 ++++
 rtl/hazard_ctrl.sv | 35 +++
 tb/tb_hazard_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline stall/flush scheduler
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int MDU_LATENCY_DEF = 4;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from D/E/M and stall/flush/MDU controls back to the pipeline
interface hazard_ctrl_if #(parameter int REG_ADDR_W = 5);
    logic [REG_ADDR_W-1:0] Rs1D, Rs2D, RdE;
    logic RegWriteE, ResultSrcE0, PCSrcE, MulDivE, MemReqM, MemReadyM;
    logic StallF, StallD, StallE, StallM;
    logic FlushD, FlushE, FlushM, FlushW;
    logic MduStart, MduBusy, MduDone;
    modport master (
        output Rs1D, Rs2D, RdE, RegWriteE, ResultSrcE0, PCSrcE, MulDivE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
        input  MduStart, MduBusy, MduDone
    );
    modport slave (
        input  Rs1D, Rs2D, RdE, RegWriteE, ResultSrcE0, PCSrcE, MulDivE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
        output MduStart, MduBusy, MduDone
    );
endinterface

// File: rtl/hazard_ctrl_mdu_sequencer.sv
// mdu_sequencer: launches the mul/div unit, counts its latency and holds the result until E can advance
module mdu_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MulDivE,
    input  logic memStall,
    output logic MduStart,
    output logic MduBusy,
    output logic MduDone,
    output logic mduStall
);
    localparam int CW = $clog2(MDU_LATENCY);
    mdu_state_t state, state_nxt;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= MduStart ? CW'(MDU_LATENCY - 1) : (state == BUSY && cnt != '0) ? cnt - CW'(1) : cnt;
        end
    end
    // counting continues through memory wait states; only DONE waits for memory
    always_comb begin
        state_nxt = (state == IDLE) ? ((MulDivE && !memStall) ? BUSY : IDLE) :
                    (state == BUSY) ? ((cnt == '0) ? DONE : BUSY) :
                    (memStall ? DONE : IDLE);
    end
    always_comb begin
        MduStart = rst_n && state == IDLE && MulDivE && !memStall;
        MduBusy  = rst_n && state == BUSY;
        MduDone  = rst_n && state == DONE;
        mduStall = rst_n && MulDivE && state != DONE;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch/memory-wait/MDU hazard detection and prioritised stall-flush encoding
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF,
    parameter int REG_ADDR_W  = 5
) (
    input logic         clk,
    input logic         rst_n,
    hazard_ctrl_if.slave bus
);
    logic mem_stall, lw_stall, mdu_stall;
    assign mem_stall = bus.MemReqM & ~bus.MemReadyM;
    assign lw_stall  = bus.ResultSrcE0 & bus.RegWriteE & (bus.RdE != REG_ADDR_W'(REG_X0)) &
                       ((bus.Rs1D == bus.RdE) | (bus.Rs2D == bus.RdE));
    mdu_sequencer #(.MDU_LATENCY(MDU_LATENCY)) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .MulDivE  (bus.MulDivE),
        .memStall (mem_stall),
        .MduStart (bus.MduStart),
        .MduBusy  (bus.MduBusy),
        .MduDone  (bus.MduDone),
        .mduStall (mdu_stall)
    );
    // memory wait freezes everything, so a branch or load-use behind it is simply re-seen later
    always_comb begin
        {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE, bus.FlushM, bus.FlushW} =
            !rst_n       ? 8'b0000_1111 :
            mem_stall    ? 8'b1111_0001 :
            mdu_stall    ? 8'b1110_0010 :
            bus.PCSrcE   ? 8'b0000_1100 :
            lw_stall     ? 8'b1100_0100 : 8'b0000_0000;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, hand sequences and random stimulus against a cycle-age reference model
module tb_hazard_ctrl;
    localparam int L = 4;
    localparam logic [10:0] RST = 11'b0000_1111_000;
    typedef struct packed {
        logic [4:0] rs1, rs2, rd;
        logic rw, ld, pc, md, mreq, mrdy;
    } in_t;
    typedef struct {
        in_t         i;
        logic [10:0] o;
        string       n;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();
    hazard_ctrl #(.MDU_LATENCY(L), .REG_ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int passed = 0, total = 0;
    int age = 0;
    vec_t tbl[10];

    function automatic in_t mk(input int rs1, rs2, rd, input logic rw, ld, pc, md, mreq, mrdy);
        in_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.rw = rw; v.ld = ld; v.pc = pc; v.md = md; v.mreq = mreq; v.mrdy = mrdy;
        return v;
    endfunction

    task automatic drive(input in_t v);
        bus.Rs1D = v.rs1; bus.Rs2D = v.rs2; bus.RdE = v.rd;
        bus.RegWriteE = v.rw; bus.ResultSrcE0 = v.ld; bus.PCSrcE = v.pc;
        bus.MulDivE = v.md; bus.MemReqM = v.mreq; bus.MemReadyM = v.mrdy;
    endtask

    function automatic logic [10:0] got();
        return {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushD, bus.FlushE,
                bus.FlushM, bus.FlushW, bus.MduStart, bus.MduBusy, bus.MduDone};
    endfunction

    // age = cycles since the MDU op launched (0 = none); busy for ages 1..L, result held at L+1
    function automatic logic [10:0] model(input in_t v);
        logic mem, lw, st, bs, dn, ms;
        logic [7:0] p;
        mem = v.mreq & ~v.mrdy;
        lw  = v.ld & v.rw & (v.rd != 0) & ((v.rs1 == v.rd) | (v.rs2 == v.rd));
        st  = (age == 0) && v.md && !mem;
        bs  = (age >= 1) && (age <= L);
        dn  = (age == L + 1);
        ms  = v.md && !dn;
        p = mem ? 8'b1111_0001 : ms ? 8'b1110_0010 : v.pc ? 8'b0000_1100 : lw ? 8'b1100_0100 : 8'b0;
        return {p, st, bs, dn};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        total++;
        if (got() !== exp) $display("FAIL %s: got %b expected %b", name, got(), exp);
        else passed++;
    endtask

    task automatic advance(input in_t v);
        int nxt;
        logic mem;
        mem = v.mreq & ~v.mrdy;
        nxt = (age == 0) ? ((v.md && !mem) ? 1 : 0) : (age <= L) ? age + 1 : (mem ? age : 0);
        @(posedge clk);
        age = nxt;
        #1;
    endtask

    task automatic cyc(input in_t v, input string name, input logic [10:0] exp);
        drive(v);
        @(negedge clk);
        check(name, exp);
        advance(v);
    endtask

    in_t idle_v, md_v, mw_v;

    initial begin
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        md_v   = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
        mw_v   = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
        tbl[0] = '{mk(5, 1, 5, 1, 1, 0, 0, 0, 0), 11'b1100_0100_000, "lw_rs1"};
        tbl[1] = '{mk(2, 7, 7, 1, 1, 0, 0, 0, 0), 11'b1100_0100_000, "lw_rs2"};
        tbl[2] = '{mk(0, 3, 0, 1, 1, 0, 0, 0, 0), 11'b0000_0000_000, "lw_x0"};
        tbl[3] = '{mk(5, 1, 5, 1, 0, 0, 0, 0, 0), 11'b0000_0000_000, "no_load"};
        tbl[4] = '{mk(5, 1, 5, 0, 1, 0, 0, 0, 0), 11'b0000_0000_000, "no_regwrite"};
        tbl[5] = '{mk(5, 1, 5, 1, 1, 1, 0, 0, 0), 11'b0000_1100_000, "branch_over_lw"};
        tbl[6] = '{mk(1, 2, 3, 1, 1, 1, 0, 0, 0), 11'b0000_1100_000, "branch"};
        tbl[7] = '{mk(1, 2, 3, 0, 0, 1, 0, 1, 0), 11'b1111_0001_000, "mem_over_branch"};
        tbl[8] = '{mk(1, 2, 3, 0, 0, 0, 0, 1, 1), 11'b0000_0000_000, "mem_ready"};
        tbl[9] = '{mk(4, 4, 4, 1, 1, 0, 0, 1, 0), 11'b1111_0001_000, "mem_over_lw"};

        drive(idle_v);
        repeat (2) @(posedge clk);
        #1 check("reset", RST);
        rst_n = 1'b1;
        age = 0;

        foreach (tbl[k]) cyc(tbl[k].i, tbl[k].n, tbl[k].o);

        // two back-to-back MDU ops with MulDivE held
        for (int r = 0; r < 2; r++) begin
            cyc(md_v, "mdu_start", 11'b1110_0010_100);
            for (int c = 1; c <= L; c++) cyc(md_v, "mdu_busy", 11'b1110_0010_010);
            cyc(md_v, "mdu_done", 11'b0000_0000_001);
        end
        cyc(idle_v, "mdu_idle", 11'b0);

        // memory wait while DONE holds the result
        cyc(md_v, "mw_start", 11'b1110_0010_100);
        for (int c = 1; c <= L; c++) cyc(md_v, "mw_busy", 11'b1110_0010_010);
        for (int c = 0; c < 3; c++) cyc(mw_v, "mw_hold", 11'b1111_0001_001);
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 1, 1), "mw_release", 11'b0000_0000_001);
        cyc(idle_v, "mw_idle", 11'b0);

        // branch deferred behind memory wait
        for (int c = 0; c < 2; c++) cyc(mk(0, 0, 0, 0, 0, 1, 0, 1, 0), "defer_branch", 11'b1111_0001_000);
        cyc(mk(0, 0, 0, 0, 0, 1, 0, 1, 1), "branch_released", 11'b0000_1100_000);

        // asynchronous reset in the middle of an MDU op
        cyc(md_v, "ar_start", 11'b1110_0010_100);
        cyc(md_v, "ar_busy", 11'b1110_0010_010);
        drive(md_v);
        #2 rst_n = 1'b0;
        #1 check("async_reset", RST);
        @(negedge clk);
        check("reset_hold_md", RST);
        @(posedge clk);
        #1 rst_n = 1'b1;
        age = 0;
        cyc(md_v, "restart", 11'b1110_0010_100);
        cyc(md_v, "restart_once", 11'b1110_0010_010);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        age = 0;

        for (int n = 0; n < 400; n++) begin
            in_t v;
            v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));
            cyc(v, "random", model(v));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
